rect_plotter: RTL and testbench

//  Pixel-generation stage feeding the vga_adapter write port (x, y, colour, plot).
//  On a start pulse, it scans a rectangle in row-major order and emits one plot per clock.

---
 rtl/rect_plotter.sv | 174 +++++++++++++++++
 tb/tb_rect_plotter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_plotter.sv
// rect_plotter: scans a rectangle in row-major order and emits one pixel per
// clock to the VGA adapter write port. Colour comes from a solid fill or from
// a synchronous colour ROM addressed by the linear pixel index.
//
//   state   | meaning
//   S_IDLE  | waiting for start; request inputs latched on acceptance
//   S_RUN   | issuing pixel index idx (one per cycle)
//   S_DRAIN | two cycles for the ROM/output pipeline to empty
//   S_DONE  | one-cycle done pulse, then back to idle
module rect_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int ADDR_W   = 15,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clock_50_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                src_rom_i,
  input  logic [X_W-1:0]      x0_i,
  input  logic [Y_W-1:0]      y0_i,
  input  logic [X_W:0]        w_i,
  input  logic [Y_W:0]        h_i,
  input  logic [COLOUR_W-1:0] fill_colour_i,
  output logic [ADDR_W-1:0]   rom_addr_o,
  input  logic [COLOUR_W-1:0] rom_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [X_W-1:0]      x_o,
  output logic [Y_W-1:0]      y_o,
  output logic [COLOUR_W-1:0] colour_o,
  output logic                plot_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [X_W:0] SCREEN_W_L = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCREEN_H_L = (Y_W+1)'(SCREEN_H);

  state_t              state_q;
  logic                busy_q, done_q, drain_q;
  logic                src_rom_q;
  logic [X_W-1:0]      x0_q, cx_q;
  logic [Y_W-1:0]      y0_q, cy_q;
  logic [X_W:0]        w_q;
  logic [Y_W:0]        h_q;
  logic [COLOUR_W-1:0] fill_q;
  logic [ADDR_W-1:0]   idx_q;

  logic                s1_valid_q, s1_in_q;
  logic [X_W-1:0]      s1_x_q;
  logic [Y_W-1:0]      s1_y_q;
  logic                plot_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;

  logic [X_W:0]        x_sum_d;
  logic [Y_W:0]        y_sum_d;
  logic                last_col_d, last_row_d;

  // Coordinate sums kept one bit wider so off-screen pixels are detected, not wrapped.
  always_comb begin
    x_sum_d    = {1'b0, x0_q} + {1'b0, cx_q};
    y_sum_d    = {1'b0, y0_q} + {1'b0, cy_q};
    last_col_d = ({1'b0, cx_q} == (w_q - 1'b1));
    last_row_d = ({1'b0, cy_q} == (h_q - 1'b1));
  end

  // Control FSM: request latch, scan counters, busy/done flags.
  always_ff @(posedge clock_50_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= 1'b0;
      src_rom_q <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      fill_q    <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      idx_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            src_rom_q <= src_rom_i;
            x0_q      <= x0_i;
            y0_q      <= y0_i;
            w_q       <= w_i;
            h_q       <= h_i;
            fill_q    <= fill_colour_i;
            cx_q      <= '0;
            cy_q      <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            if (w_i == '0 || h_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (last_col_d) begin
            cx_q <= '0;
            if (last_row_d) begin
              state_q <= S_DRAIN;
              drain_q <= 1'b0;
            end else begin
              cy_q <= cy_q + 1'b1;
            end
          end else begin
            cx_q <= cx_q + 1'b1;
          end
          // idx stays on the final address so rom_addr shows N-1 after the scan.
          if (!(last_col_d && last_row_d)) idx_q <= idx_q + 1'b1;
        end
        S_DRAIN: begin
          if (drain_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Two-stage output pipeline aligned with the one-cycle ROM latency.
  always_ff @(posedge clock_50_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_in_q    <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      plot_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
    end else begin
      s1_valid_q <= (state_q == S_RUN);
      s1_in_q    <= (x_sum_d < SCREEN_W_L) && (y_sum_d < SCREEN_H_L);
      s1_x_q     <= x_sum_d[X_W-1:0];
      s1_y_q     <= y_sum_d[Y_W-1:0];
      plot_q     <= s1_valid_q && s1_in_q;
      x_q        <= s1_x_q;
      y_q        <= s1_y_q;
      colour_q   <= src_rom_q ? rom_data_i : fill_q;
    end
  end

  assign rom_addr_o = idx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign x_o        = x_q;
  assign y_o        = y_q;
  assign colour_o   = colour_q;
  assign plot_o     = plot_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Testbench for rect_plotter: expected pixels are queued at launch and
// popped by a monitor as plot strobes appear.
module tb_rect_plotter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        src_rom = 1'b0;
  logic [7:0]  x0 = '0;
  logic [6:0]  y0 = '0;
  logic [8:0]  w = '0;
  logic [7:0]  h = '0;
  logic [2:0]  fill = '0;
  logic [14:0] rom_addr;
  logic [2:0]  rom_data = '0;
  logic        busy, done, plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   plot_cnt = 0;
  int   first_plot_cyc = -1;

  rect_plotter dut (
    .clock_50_i   (clk),
    .reset_i      (reset),
    .start_i      (start),
    .src_rom_i    (src_rom),
    .x0_i         (x0),
    .y0_i         (y0),
    .w_i          (w),
    .h_i          (h),
    .fill_colour_i(fill),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .busy_o       (busy),
    .done_o       (done),
    .x_o          (x),
    .y_o          (y),
    .colour_o     (colour),
    .plot_o       (plot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Colour ROM model: one-cycle latency, word = low address bits.
  always @(posedge clk) rom_data <= rom_addr[2:0];

  // Scoreboard monitor: every plot strobe must match the next expected pixel.
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      pix_t e;
      plot_cnt++;
      if (first_plot_cyc < 0) first_plot_cyc = cyc;
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_plot: got (%0d,%0d) c=%0d, expected no plot", x, y, colour);
      end else begin
        e = exp_q.pop_front();
        if ({x, y, colour} !== {e.x, e.y, e.c}) begin
          n_fail++;
          $display("FAIL pixel: got (%0d,%0d) c=%0d, expected (%0d,%0d) c=%0d",
                   x, y, colour, e.x, e.y, e.c);
        end
      end
    end
  end

  // Drive a request for one cycle, queue the expected visible pixels,
  // and return the cycle count of the acceptance edge.
  task automatic launch(input int ax0, input int ay0, input int aw, input int ah,
                        input logic [2:0] afill, input logic asrc, output int e);
    for (int r = 0; r < ah; r++) begin
      for (int c = 0; c < aw; c++) begin
        int   xs, ys, idx;
        pix_t p;
        xs  = ax0 + c;
        ys  = ay0 + r;
        idx = r * aw + c;
        if (xs < 160 && ys < 120) begin
          p.x = 8'(xs);
          p.y = 7'(ys);
          p.c = asrc ? 3'(idx) : afill;
          exp_q.push_back(p);
        end
      end
    end
    plot_cnt       = 0;
    first_plot_cyc = -1;
    @(negedge clk);
    x0      = 8'(ax0);
    y0      = 7'(ay0);
    w       = 9'(aw);
    h       = 8'(ah);
    fill    = afill;
    src_rom = asrc;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e     = cyc;
  endtask

  // Wait (bounded) for the done pulse; reports the cycle it was seen on.
  task automatic wait_done(input int budget, output logic found, output int at);
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        found = 1'b1;
        at    = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_assert += 7;
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
    if (plot !== 1'b0)       begin n_fail++; $display("FAIL reset_plot: got %b, expected 0", plot); end
    if (x !== 8'd0)          begin n_fail++; $display("FAIL reset_x: got %0d, expected 0", x); end
    if (y !== 7'd0)          begin n_fail++; $display("FAIL reset_y: got %0d, expected 0", y); end
    if (colour !== 3'd0)     begin n_fail++; $display("FAIL reset_colour: got %0d, expected 0", colour); end
    if (rom_addr !== 15'd0)  begin n_fail++; $display("FAIL reset_rom_addr: got %0d, expected 0", rom_addr); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    int e, at;
    logic found;
    launch(10, 20, 3, 2, 3'b101, 1'b0, e);
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %b, expected 1", busy); end
    wait_done(50, found, at);
    n_assert += 5;
    if (!found)           begin n_fail++; $display("FAIL fill_done_timeout: got no done, expected done"); end
    if (at !== e + 8)     begin n_fail++; $display("FAIL fill_done_cycle: got %0d, expected %0d", at, e + 8); end
    if (plot !== 1'b0)    begin n_fail++; $display("FAIL fill_plot_at_done: got %b, expected 0", plot); end
    if (plot_cnt !== 6)   begin n_fail++; $display("FAIL fill_plot_count: got %0d, expected 6", plot_cnt); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL fill_missing: got %0d left, expected 0", exp_q.size()); end
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_rom();
    int e, at;
    logic found;
    launch(0, 0, 4, 1, 3'd0, 1'b1, e);
    for (int k = 0; k < 4; k++) begin
      n_assert++;
      if (rom_addr !== 15'(k)) begin n_fail++; $display("FAIL rom_addr_seq: got %0d, expected %0d", rom_addr, k); end
      @(negedge clk);
    end
    wait_done(50, found, at);
    n_assert += 4;
    if (!found)                  begin n_fail++; $display("FAIL rom_done_timeout: got no done, expected done"); end
    if (at !== e + 6)            begin n_fail++; $display("FAIL rom_done_cycle: got %0d, expected %0d", at, e + 6); end
    if (first_plot_cyc !== e + 2) begin n_fail++; $display("FAIL rom_first_plot: got %0d, expected %0d", first_plot_cyc, e + 2); end
    if (plot_cnt !== 4)          begin n_fail++; $display("FAIL rom_plot_count: got %0d, expected 4", plot_cnt); end
    @(negedge clk);
  endtask

  task automatic test_clip();
    int e, at;
    logic found;
    launch(158, 119, 4, 2, 3'd0, 1'b1, e);
    repeat (7) @(negedge clk);
    n_assert++;
    if (rom_addr !== 15'd7) begin n_fail++; $display("FAIL clip_rom_addr: got %0d, expected 7", rom_addr); end
    wait_done(50, found, at);
    n_assert += 4;
    if (!found)            begin n_fail++; $display("FAIL clip_done_timeout: got no done, expected done"); end
    if (at !== e + 10)     begin n_fail++; $display("FAIL clip_done_cycle: got %0d, expected %0d", at, e + 10); end
    if (plot_cnt !== 2)    begin n_fail++; $display("FAIL clip_plot_count: got %0d, expected 2", plot_cnt); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL clip_missing: got %0d left, expected 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int e;
    launch(5, 5, 0, 5, 3'd1, 1'b0, e);
    n_assert += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b, expected 1", busy); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b, expected 1", done); end
    @(negedge clk);
    @(negedge clk);
    n_assert += 2;
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL zero_idle: got busy %b, expected 0", busy); end
    if (plot_cnt !== 0) begin n_fail++; $display("FAIL zero_plots: got %0d, expected 0", plot_cnt); end
  endtask

  task automatic test_full();
    int e, at;
    logic found;
    launch(0, 0, 160, 120, 3'd0, 1'b1, e);
    wait_done(19400, found, at);
    n_assert += 5;
    if (!found)                begin n_fail++; $display("FAIL full_done_timeout: got no done, expected done"); end
    if (at !== e + 19202)      begin n_fail++; $display("FAIL full_done_cycle: got %0d, expected %0d", at, e + 19202); end
    if (plot_cnt !== 19200)    begin n_fail++; $display("FAIL full_plot_count: got %0d, expected 19200", plot_cnt); end
    if (rom_addr !== 15'd19199) begin n_fail++; $display("FAIL full_last_addr: got %0d, expected 19199", rom_addr); end
    if (exp_q.size() != 0)     begin n_fail++; $display("FAIL full_missing: got %0d left, expected 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_abort_collision();
    int e, at, done_seen;
    logic found;
    launch(20, 30, 10, 10, 3'd2, 1'b0, e);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin
        x0    = 8'd100;
        fill  = 3'd7;
        start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      if (k == 40) reset = 1'b1;
    end
    @(negedge clk);
    n_assert += 3;
    if (plot !== 1'b0)      begin n_fail++; $display("FAIL abort_plot: got %b, expected 0", plot); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b, expected 0", busy); end
    if (plot_cnt !== 39)    begin n_fail++; $display("FAIL abort_plot_count: got %0d, expected 39", plot_cnt); end
    reset = 1'b0;
    n_assert++;
    if (exp_q.size() != 61) begin n_fail++; $display("FAIL abort_left: got %0d left, expected 61", exp_q.size()); end
    exp_q.delete();
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1 || plot === 1'b1) done_seen++;
    end
    n_assert++;
    if (done_seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d strobes, expected 0", done_seen); end
    launch(7, 3, 2, 2, 3'd6, 1'b0, e);
    wait_done(50, found, at);
    n_assert += 4;
    if (!found)            begin n_fail++; $display("FAIL restart_done_timeout: got no done, expected done"); end
    if (at !== e + 6)      begin n_fail++; $display("FAIL restart_done_cycle: got %0d, expected %0d", at, e + 6); end
    if (plot_cnt !== 4)    begin n_fail++; $display("FAIL restart_plot_count: got %0d, expected 4", plot_cnt); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL restart_missing: got %0d left, expected 0", exp_q.size()); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_rom();
    test_clip();
    test_zero();
    test_full();
    test_abort_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
